// File: rtl/pong_game_ctrl_if.sv
// Bundle between the Pong game engine and its surroundings: player controls
// and frame tick in, ball/paddle/score state out to the pixel generator.
interface pong_game_ctrl_if;
   logic       refresh_tick;
   logic       start;
   logic       p1_up;
   logic       p1_dn;
   logic       p2_up;
   logic       p2_dn;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] paddle1_y;
   logic [9:0] paddle2_y;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] game_state;
   logic       hit;
   logic       miss;

   modport master (
      output refresh_tick, start, p1_up, p1_dn, p2_up, p2_dn,
      input  ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
             game_state, hit, miss
   );

   modport slave (
      input  refresh_tick, start, p1_up, p1_dn, p2_up, p2_dn,
      output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
             game_state, hit, miss
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong engine: serve/play/point/over FSM, clamped paddle motion,
// ball wall bounce, paddle rebound and miss scoring, all advanced on refresh_tick.
module pong_game_ctrl #(
   parameter int BALL_VEL    = 4,
   parameter int PADDLE_VEL  = 3,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 9
) (
   input  logic             clk,
   input  logic             reset,
   pong_game_ctrl_if.slave  bus
);
   localparam logic [9:0] BV            = 10'(BALL_VEL);
   localparam logic [9:0] PV            = 10'(PADDLE_VEL);
   localparam logic [9:0] BALL_CX       = 10'd316;
   localparam logic [9:0] BALL_CY       = 10'd236;
   localparam logic [9:0] PAD_CY        = 10'd204;
   localparam logic [9:0] PAD_MAX       = 10'd407;
   localparam logic [9:0] BALL_Y_MAX    = 10'd472;
   localparam logic [9:0] PAD_SPAN      = 10'd72;
   localparam logic [9:0] BALL_SPAN     = 10'd7;
   localparam logic [9:0] LEFT_EDGE     = 10'd40 + BV;
   localparam logic [9:0] RIGHT_EDGE    = 10'd593;
   localparam logic [9:0] LEFT_REBOUND  = 10'd41;
   localparam logic [9:0] RIGHT_REBOUND = 10'd592;
   localparam int         CNT_W         = $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0] WIN           = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      POINT = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t           state;
   logic [9:0]       ball_x;
   logic [9:0]       ball_y;
   logic [9:0]       pad1_y;
   logic [9:0]       pad2_y;
   logic             dx_neg;
   logic             dy_neg;
   logic [3:0]       score1;
   logic [3:0]       score2;
   logic [CNT_W-1:0] frame_cnt;
   logic             hit;
   logic             miss;

   logic [9:0]       step_x;
   logic [9:0]       step_y;
   logic             step_dx_neg;
   logic             step_dy_neg;
   logic             bounce;
   logic             p1_point;
   logic             p2_point;

   // Compare against the limit before stepping so the 10-bit value never wraps.
   function automatic logic [9:0] paddle_step(input logic [9:0] y,
                                              input logic up,
                                              input logic dn);
      if (up && !dn)
         return (y < PV) ? 10'd0 : y - PV;
      else if (dn && !up)
         return (y > PAD_MAX - PV) ? PAD_MAX : y + PV;
      return y;
   endfunction

   function automatic logic overlaps(input logic [9:0] by, input logic [9:0] py);
      return (by + BALL_SPAN >= py) && (by <= py + PAD_SPAN);
   endfunction

   always_comb begin
      step_y      = ball_y;
      step_dy_neg = dy_neg;
      if (dy_neg) begin
         if (ball_y < BV) begin
            step_y      = 10'd0;
            step_dy_neg = 1'b0;
         end else begin
            step_y = ball_y - BV;
         end
      end else begin
         if (ball_y + BV > BALL_Y_MAX) begin
            step_y      = BALL_Y_MAX;
            step_dy_neg = 1'b1;
         end else begin
            step_y = ball_y + BV;
         end
      end

      step_x      = ball_x;
      step_dx_neg = dx_neg;
      bounce      = 1'b0;
      p1_point    = 1'b0;
      p2_point    = 1'b0;
      if (dx_neg) begin
         if (ball_x <= LEFT_EDGE) begin
            if (overlaps(ball_y, pad1_y)) begin
               step_x      = LEFT_REBOUND;
               step_dx_neg = 1'b0;
               bounce      = 1'b1;
            end else begin
               p2_point = 1'b1;
            end
         end else begin
            step_x = ball_x - BV;
         end
      end else begin
         if (ball_x + BV >= RIGHT_EDGE) begin
            if (overlaps(ball_y, pad2_y)) begin
               step_x      = RIGHT_REBOUND;
               step_dx_neg = 1'b1;
               bounce      = 1'b1;
            end else begin
               p1_point = 1'b1;
            end
         end else begin
            step_x = ball_x + BV;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ball_x    <= BALL_CX;
         ball_y    <= BALL_CY;
         pad1_y    <= PAD_CY;
         pad2_y    <= PAD_CY;
         dx_neg    <= 1'b0;
         dy_neg    <= 1'b0;
         score1    <= 4'd0;
         score2    <= 4'd0;
         frame_cnt <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
      end else begin
         hit  <= 1'b0;
         miss <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start)
                  state <= PLAY;
            end
            PLAY: begin
               if (bus.refresh_tick) begin
                  pad1_y <= paddle_step(pad1_y, bus.p1_up, bus.p1_dn);
                  pad2_y <= paddle_step(pad2_y, bus.p2_up, bus.p2_dn);
                  // On a miss dx already points at the conceding side, so it is kept.
                  if (p1_point || p2_point) begin
                     miss      <= 1'b1;
                     ball_x    <= BALL_CX;
                     ball_y    <= BALL_CY;
                     frame_cnt <= '0;
                     if (p1_point) begin
                        score1 <= score1 + 4'd1;
                        state  <= (score1 + 4'd1 == WIN) ? OVER : POINT;
                     end else begin
                        score2 <= score2 + 4'd1;
                        state  <= (score2 + 4'd1 == WIN) ? OVER : POINT;
                     end
                  end else begin
                     ball_x <= step_x;
                     ball_y <= step_y;
                     dx_neg <= step_dx_neg;
                     dy_neg <= step_dy_neg;
                     hit    <= bounce;
                  end
               end
            end
            POINT: begin
               if (bus.refresh_tick) begin
                  pad1_y    <= paddle_step(pad1_y, bus.p1_up, bus.p1_dn);
                  pad2_y    <= paddle_step(pad2_y, bus.p2_up, bus.p2_dn);
                  frame_cnt <= frame_cnt + CNT_ONE;
                  if (frame_cnt == SERVE_LAST)
                     state <= PLAY;
               end
            end
            OVER: begin
               if (bus.start) begin
                  state  <= PLAY;
                  ball_x <= BALL_CX;
                  ball_y <= BALL_CY;
                  pad1_y <= PAD_CY;
                  pad2_y <= PAD_CY;
                  dx_neg <= 1'b0;
                  dy_neg <= 1'b0;
                  score1 <= 4'd0;
                  score2 <= 4'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ball_x     = ball_x;
   assign bus.ball_y     = ball_y;
   assign bus.paddle1_y  = pad1_y;
   assign bus.paddle2_y  = pad2_y;
   assign bus.score1     = score1;
   assign bus.score2     = score2;
   assign bus.game_state = state;
   assign bus.hit        = hit;
   assign bus.miss       = miss;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl: every cycle is compared against a
// frame-level game model, plus directed checks of paddle clamping and game end.
module tb_pong_game_ctrl;
   localparam int BALL_VEL    = 4;
   localparam int PADDLE_VEL  = 3;
   localparam int SERVE_DELAY = 60;
   localparam int WIN_SCORE   = 9;

   logic clk = 1'b0;
   logic reset = 1'b0;
   pong_game_ctrl_if bus();

   pong_game_ctrl #(
      .BALL_VEL(BALL_VEL), .PADDLE_VEL(PADDLE_VEL),
      .SERVE_DELAY(SERVE_DELAY), .WIN_SCORE(WIN_SCORE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Game model: positions as plain integers, velocities as signed unit steps.
   int m_state, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_cnt, m_hit, m_miss;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int move_pad(input int y, input bit up, input bit dn);
      int r = y;
      if (up && !dn) r = y - PADDLE_VEL;
      else if (dn && !up) r = y + PADDLE_VEL;
      if (r < 0) r = 0;
      if (r > 407) r = 407;
      return r;
   endfunction

   task automatic model_centre_all();
      m_bx = 316; m_by = 236; m_p1 = 204; m_p2 = 204;
      m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
   endtask

   task automatic model_ball(input int old_p1, input int old_p2);
      int ny, ndy, pad;
      bit reach;
      ny  = m_by + BALL_VEL * m_dy;
      ndy = m_dy;
      if (ny < 0)   begin ny = 0;   ndy = 1;  end
      if (ny > 472) begin ny = 472; ndy = -1; end
      reach = (m_dx < 0) ? (m_bx - BALL_VEL <= 40) : (m_bx + BALL_VEL >= 593);
      if (!reach) begin
         m_bx = m_bx + BALL_VEL * m_dx;
         m_by = ny; m_dy = ndy;
         return;
      end
      pad = (m_dx < 0) ? old_p1 : old_p2;
      if (m_by + 7 >= pad && m_by <= pad + 72) begin
         m_bx = (m_dx < 0) ? 41 : 592;
         m_dx = -m_dx;
         m_by = ny; m_dy = ndy;
         m_hit = 1;
      end else begin
         m_miss = 1;
         if (m_dx < 0) m_s2++; else m_s1++;
         m_bx = 316; m_by = 236;
         m_cnt = 0;
         m_state = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) ? 3 : 2;
      end
   endtask

   task automatic model_step(input bit rst, input bit st, input bit tk,
                             input bit u1, input bit d1, input bit u2, input bit d2);
      int old_p1, old_p2;
      m_hit = 0; m_miss = 0;
      if (rst) begin
         model_centre_all();
         m_state = 0; m_cnt = 0;
         return;
      end
      case (m_state)
         0: if (st) m_state = 1;
         3: if (st) begin model_centre_all(); m_state = 1; end
         default: if (tk) begin
            old_p1 = m_p1; old_p2 = m_p2;
            m_p1 = move_pad(m_p1, u1, d1);
            m_p2 = move_pad(m_p2, u2, d2);
            if (m_state == 2) begin
               m_cnt++;
               if (m_cnt == SERVE_DELAY) m_state = 1;
            end else begin
               model_ball(old_p1, old_p2);
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("game_state", int'(bus.game_state), m_state);
      check("ball_x",     int'(bus.ball_x),     m_bx);
      check("ball_y",     int'(bus.ball_y),     m_by);
      check("paddle1_y",  int'(bus.paddle1_y),  m_p1);
      check("paddle2_y",  int'(bus.paddle2_y),  m_p2);
      check("score1",     int'(bus.score1),     m_s1);
      check("score2",     int'(bus.score2),     m_s2);
      check("hit",        int'(bus.hit),        m_hit);
      check("miss",       int'(bus.miss),       m_miss);
   endtask

   task automatic step(input bit rst, input bit st, input bit tk,
                       input bit u1, input bit d1, input bit u2, input bit d2);
      reset            = rst;
      bus.start        = st;
      bus.refresh_tick = tk;
      bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
      @(posedge clk);
      model_step(rst, st, tk, u1, d1, u2, d2);
      #1;
      compare_all();
   endtask

   // Left paddle follows the ball; right paddle drifts randomly and usually misses.
   task automatic chase_step(input bit st);
      bit u1, d1, u2, d2;
      u1 = (m_by + 4 < m_p1 + 34);
      d1 = (m_by + 4 > m_p1 + 38);
      u2 = 1'($urandom_range(0, 1));
      d2 = 1'($urandom_range(0, 1));
      step(0, st, 1, u1, d1, u2, d2);
   endtask

   initial begin
      bit [3:0] btn;
      bus.start = 0; bus.refresh_tick = 0;
      bus.p1_up = 0; bus.p1_dn = 0; bus.p2_up = 0; bus.p2_dn = 0;
      m_state = 0; m_cnt = 0; m_hit = 0; m_miss = 0;
      model_centre_all();

      repeat (2) step(1, 0, 1, 0, 0, 0, 0);
      check("rst_state",  int'(bus.game_state), 0);
      check("rst_ball_x", int'(bus.ball_x), 316);
      check("rst_ball_y", int'(bus.ball_y), 236);
      check("rst_pad1",   int'(bus.paddle1_y), 204);

      step(0, 0, 1, 1, 0, 0, 1);
      check("idle_frozen_pad1", int'(bus.paddle1_y), 204);
      step(0, 1, 1, 0, 0, 0, 0);
      check("start_state",  int'(bus.game_state), 1);
      check("start_ball_x", int'(bus.ball_x), 316);
      step(0, 0, 1, 0, 0, 0, 0);
      check("tick1_ball_x", int'(bus.ball_x), 320);
      check("tick1_ball_y", int'(bus.ball_y), 240);
      step(0, 0, 1, 1, 1, 1, 1);
      check("both_pad1", int'(bus.paddle1_y), 204);
      check("both_pad2", int'(bus.paddle2_y), 204);

      repeat (67) step(0, 0, 1, 1, 0, 0, 1);
      check("up67_pad1", int'(bus.paddle1_y), 3);
      check("dn67_pad2", int'(bus.paddle2_y), 405);
      step(0, 0, 1, 1, 0, 0, 1);
      check("up68_pad1", int'(bus.paddle1_y), 0);
      check("dn68_pad2", int'(bus.paddle2_y), 407);
      step(0, 0, 1, 1, 0, 0, 1);
      check("up69_pad1", int'(bus.paddle1_y), 0);
      check("dn69_pad2", int'(bus.paddle2_y), 407);

      // Play one full game through to OVER.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8000 && bus.game_state != 2'd3; i++)
         chase_step(0);
      check("over_reached", int'(bus.game_state), 3);
      repeat (10) chase_step(0);
      check("over_ball_x", int'(bus.ball_x), 316);
      check("over_state",  int'(bus.game_state), 3);
      chase_step(1);
      check("restart_state",  int'(bus.game_state), 1);
      check("restart_score1", int'(bus.score1), 0);
      check("restart_score2", int'(bus.score2), 0);

      // Reset in the middle of the serve delay.
      for (int i = 0; i < 2000 && bus.miss != 1'b1; i++)
         chase_step(0);
      check("first_miss", int'(bus.miss), 1);
      repeat (20) chase_step(0);
      check("mid_point_state", int'(bus.game_state), 2);
      step(1, 0, 1, 0, 0, 0, 0);
      check("point_rst_state",  int'(bus.game_state), 0);
      check("point_rst_score1", int'(bus.score1), 0);
      check("point_rst_score2", int'(bus.score2), 0);

      // Free-running random traffic.
      btn = 4'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
         step(($urandom_range(0, 1999) == 0),
              ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 3) != 0),
              btn[0], btn[1], btn[2], btn[3]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game engine for the Pong display path. Produces the ball position, both paddle positions and the scores.
- Its outputs drive the pixel generator directly. They update only on refresh_tick, a one-cycle pulse at vertical blank, so they stay stable while a frame is being drawn.
- Contains the serve/play/point/game-over state machine, paddle motion with clamping, and ball bounce and miss detection.

Parameters:
- BALL_VEL, 4, ball displacement per axis per frame in pixels (1..7).
- PADDLE_VEL, 3, paddle displacement per frame in pixels.
- SERVE_DELAY, 60, frames held in POINT before the next serve.
- WIN_SCORE, 9, score that ends the game (≤15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- refresh_tick  in  1  one-cycle frame pulse; all motion occurs on edges where it is high
- start  in  1  one-cycle pulse; starts or restarts the game
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle controls, already debounced and synchronised
- ball_x, ball_y  out  10  top-left corner of the 8x8 ball
- paddle1_y, paddle2_y  out  10  top of each paddle (paddle spans y..y+72)
- score1, score2  out  4  player scores
- game_state  out  2  IDLE=0, PLAY=1, POINT=2, OVER=3
- hit  out  1  one-cycle pulse on a paddle bounce
- miss  out  1  one-cycle pulse when a point is scored

Behaviour:
- Geometry:
  - Screen is 640x480. Walls occupy x<32 and x>608.
  - Left paddle occupies x 32..40; right paddle occupies x 600..608.
  - Paddle y range is 0..407. Ball y range is 0..472.
  - Centre position is ball (316,236), paddles 204.
- Reset (next edge, in any state, overriding refresh_tick):
  - Ball at centre, paddles at 204, scores 0, state IDLE.
  - dx=+, dy=+; hit=0, miss=0.
- IDLE:
  - Ball and paddles are frozen.
  - start moves to PLAY on the next edge.
  - No motion occurs on the edge where start is taken, even if refresh_tick is also high.
- Paddles (PLAY and POINT, on refresh_tick):
  - up only: y -= PADDLE_VEL, clamped at 0.
  - down only: y += PADDLE_VEL, clamped at 407.
  - Both or neither pressed: no change.
  - Compare before subtracting so no 10-bit underflow occurs.
- Ball (PLAY only, on refresh_tick; x and y evaluated independently in the same tick):
  - Vertical:
    - dy=- and ball_y < BALL_VEL: ball_y=0, dy=+.
    - dy=+ and ball_y+BALL_VEL > 472: ball_y=472, dy=-.
    - Otherwise ball_y ± BALL_VEL.
  - Overlap test for paddle p: ball_y+7 >= p_y and ball_y <= p_y+72. Inclusive; a touching edge counts.
  - Leftward (dx=-):
    - If ball_x <= 40+BALL_VEL and overlap with paddle1: ball_x=41, dx=+, hit=1.
    - If ball_x <= 40+BALL_VEL without overlap: player 2 scores.
    - Otherwise ball_x -= BALL_VEL.
  - Rightward (dx=+):
    - If ball_x+BALL_VEL >= 593 and overlap with paddle2: ball_x=592, dx=-, hit=1.
    - If ball_x+BALL_VEL >= 593 without overlap: player 1 scores.
    - Otherwise ball_x += BALL_VEL.
  - A corner case (wall bounce and paddle hit in the same tick) applies both results.
- Scoring (on the same edge as the miss):
  - Scorer's count increments by 1; miss=1.
  - Ball moves to centre and the y-step is discarded.
  - dx points toward the conceding player; dy is unchanged.
  - If the new score equals WIN_SCORE, go to OVER; otherwise go to POINT and clear the frame counter.
- POINT:
  - Ball frozen at centre; paddles still move.
  - The frame counter increments on each refresh_tick.
  - On the tick where it reaches SERVE_DELAY, go to PLAY. Ball motion starts on the following tick.
  - start is ignored.
- OVER:
  - Everything frozen; scores are held.
  - start clears scores, centres ball and paddles, sets dx=+, dy=+, and goes to PLAY.
- Pulses: hit and miss are high for exactly one cycle and are otherwise 0. They are never both set in the same cycle.
- Edges without refresh_tick change no output except via start or reset.

Test Plan:
- Reset then start pulse, then one refresh_tick (BALL_VEL=4) -> state=PLAY; ball (320,240); paddles 204; scores 0.
- Hold p1_up, PLAY -> paddle1_y=0 after 68 ticks, stays 0. Hold p2_dn -> 405 after 67 ticks, 407 on tick 68, then stays. Both p1 buttons held -> no change.
- Place ball_y=2 with dy=- -> next tick ball_y=0, dy=+. Place ball_y=470 with dy=+ -> ball_y=472, dy=-.
- Left paddle hit: ball_x=44, dx=-, ball_y=193, paddle1_y=200 (ball_y+7=200, touching) -> ball_x=41, dx=+, hit pulse for 1 cycle. Same setup with ball_y=192 -> miss, score2=1, state POINT, ball (316,236), dx=-.
- POINT timing: after the miss, 59 ticks -> still POINT with ball at centre; 60th tick -> PLAY; 61st tick -> ball_x=312. Asserting reset mid-POINT -> IDLE next edge with scores 0.
- score1=8, right-side miss -> score1=9, state OVER, ball frozen through 10 ticks. start -> scores 0, ball centre, PLAY.
